bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Two-requester arbiter and sequencer for one port of the MicroBlaze BRAM block. It lets a local-bus-side requester (index 0) and a capture/DMA requester (index 1) share a single BRAM port. The arbiter accepts word commands through a req/ack handshake and drives registered BRAM_EN/BRAM_WEN/BRAM_Addr/BRAM_Dout. It returns read data with a tagged valid strobe. The grant is round-robin with a bounded burst length, so neither requester can starve the other.

## Interface
- C_PORT_DWIDTH, 32, data width of the BRAM port and of each requester.
- C_PORT_AWIDTH, 32, byte-address width, big-endian bit order [0:C_PORT_AWIDTH-1].
- C_NUM_WE, 4, byte write enables per word, with C_NUM_WE*8 = C_PORT_DWIDTH.
- C_MAX_BURST, 8, maximum consecutive grants to one requester while the other is requesting. Range 1..255.
- BRAM_Clk  in  1  single clock for the arbiter and the BRAM port.
- BRAM_Rst_N  in  1  asynchronous, active-low reset.
- Req_0 / Req_1  in  1  command request. Command fields must be held stable until the matching Ack.
- WE_0 / WE_1  in  C_NUM_WE  byte enables. All-zero means read.
- Addr_0 / Addr_1  in  C_PORT_AWIDTH  byte address.
- WData_0 / WData_1  in  C_PORT_DWIDTH  write data.
- Ack_0 / Ack_1  out  1  one-cycle pulse that accepts the command presented in the same cycle.
- RData_0 / RData_1  out  C_PORT_DWIDTH  read data, meaningful only while RValid is high.
- RValid_0 / RValid_1  out  1  one-cycle read-data strobe.
- BRAM_EN  out  1, BRAM_WEN  out  C_NUM_WE, BRAM_Addr  out  C_PORT_AWIDTH, BRAM_Dout  out  C_PORT_DWIDTH: port drive. BRAM_Dout carries write data into the BRAM.
- BRAM_Din  in  C_PORT_DWIDTH  read data from the BRAM.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN0 / OWN1: the requester currently holding the grant.
- burst_cnt (8 bits) counts consecutive grants to the current owner.
- last (1 bit) records the most recent owner.
- Transitions, evaluated every cycle:
  - IDLE, exactly one requester active: grant it and enter OWNx with burst_cnt=1.
  - IDLE, both requesting: grant !last.
  - OWNx, Req_x high, other requester idle: grant x; burst_cnt saturates at C_MAX_BURST.
  - OWNx, Req_x high, other requesting, burst_cnt < C_MAX_BURST: grant x and increment burst_cnt.
  - OWNx, Req_x high, other requesting, burst_cnt = C_MAX_BURST: grant the other, enter OWN(other), burst_cnt=1.
  - OWNx, Req_x low, other requesting: grant the other and switch, burst_cnt=1.
  - OWNx, Req_x low, other idle: no grant, go to IDLE. last keeps x.
- Grant behaviour:
  - A grant asserts Ack of the granted requester (combinational from the current state and Req) in the same cycle.
  - At most one Ack per cycle.
  - A grant updates last.
- On an accepted command, the registered port outputs load at the next edge:
  - BRAM_EN=1.
  - BRAM_WEN=WE_x.
  - BRAM_Addr=Addr_x with the two LSBs (bits [C_PORT_AWIDTH-2:C_PORT_AWIDTH-1]) forced to 0.
  - BRAM_Dout=WData_x.
- With no accepted command: BRAM_EN=0 and BRAM_WEN=0. BRAM_Addr and BRAM_Dout hold their last values.
- Read tagging:
  - A two-stage shift register carries {is_read, owner} for each command.
  - RValid_owner pulses when the read data returns.
  - RData_0 and RData_1 both drive BRAM_Din directly, unregistered.
- Writes produce no RValid.
- Requests with Req low are ignored regardless of field contents.

## Timing
- Reset values (asynchronous, while BRAM_Rst_N=0): every output is 0, FSM=IDLE, burst_cnt=0, last=1 (so requester 0 wins the first tie), tag pipeline cleared.
- Reset mid-operation drops in-flight reads: no RValid after reset is released.
- Ack_x is high in cycle N. BRAM_EN is high in cycle N+1. The BRAM samples at the end of N+1. RValid_x and valid BRAM_Din appear in cycle N+2.
- Read latency from Ack to RValid is 2 cycles.
- Throughput is one command per cycle, including back-to-back commands from alternating requesters.
- Simultaneous read and write in consecutive cycles to the same address: the BRAM port's WRITE_FIRST default applies. The arbiter does not reorder commands.
- Fairness bound: while both requesters hold Req, each waits at most C_MAX_BURST cycles between its Acks.

## Test plan
- Reset, then a single read: Req_0=1, Addr_0=0x0000_0104, WE_0=0. Required: Ack_0 in cycle 0; BRAM_EN=1 and BRAM_Addr=0x0000_0104 in cycle 1; RValid_0=1 with RData_0 equal to the preloaded word in cycle 2; RValid_1 stays 0.
- Byte write, then readback: requester 1 writes WE_1=4'b0010 (bit order [0:3]), Addr_1=0x8, WData_1=0xAABBCCDD to a word preloaded with 0x11223344. Required: a later read returns 0x1122CC44.
- Tie at reset: both Req high from cycle 0, C_MAX_BURST=8. Required: Ack_0 in cycles 0-7, Ack_1 in cycles 8-15, Ack_0 resumes in cycle 16, and exactly one Ack per cycle.
- Owner drop: requester 0 holds Req for 3 cycles while requester 1 requests continuously. Required: Ack_1 is granted in the cycle after requester 0 drops Req, with no idle bubble.
- Reset mid-read: assert BRAM_Rst_N=0 in cycle 1 after Ack_0 for a read. Required: all outputs 0 at once, and no RValid_0 after release.
- Unaligned address: Addr_0=0x0000_0107. Required: BRAM_Addr=0x0000_0104.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Purpose: round-robin arbiter sharing one BRAM port between requester 0 and requester 1, with registered port drive.
// Latency: Ack in cycle N, BRAM_EN in N+1, RValid with BRAM_Din in N+2; one command per cycle.
// Backpressure: req/ack handshake; a requester holds its fields until Ack, and bursts are capped at C_MAX_BURST while the other waits.
//
// Vectors are declared descending. Big-endian index k of a [0:W-1] field is bit W-1-k here,
// so numeric values are unchanged. The two address LSBs are value bits [1:0], and
// byte enable bit j covers data bits [8j+7:8j].
module bram_port_arbiter #(
    parameter int C_PORT_DWIDTH = 32,
    parameter int C_PORT_AWIDTH = 32,
    parameter int C_NUM_WE      = 4,
    parameter int C_MAX_BURST   = 8
) (
    input  logic                     BRAM_Clk,
    input  logic                     BRAM_Rst_N,
    input  logic                     Req_0,
    input  logic [C_NUM_WE-1:0]      WE_0,
    input  logic [C_PORT_AWIDTH-1:0] Addr_0,
    input  logic [C_PORT_DWIDTH-1:0] WData_0,
    output logic                     Ack_0,
    output logic [C_PORT_DWIDTH-1:0] RData_0,
    output logic                     RValid_0,
    input  logic                     Req_1,
    input  logic [C_NUM_WE-1:0]      WE_1,
    input  logic [C_PORT_AWIDTH-1:0] Addr_1,
    input  logic [C_PORT_DWIDTH-1:0] WData_1,
    output logic                     Ack_1,
    output logic [C_PORT_DWIDTH-1:0] RData_1,
    output logic                     RValid_1,
    output logic                     BRAM_EN,
    output logic [C_NUM_WE-1:0]      BRAM_WEN,
    output logic [C_PORT_AWIDTH-1:0] BRAM_Addr,
    output logic [C_PORT_DWIDTH-1:0] BRAM_Dout,
    input  logic [C_PORT_DWIDTH-1:0] BRAM_Din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] L_MAX = 8'(C_MAX_BURST);
    localparam logic [C_PORT_AWIDTH-1:0] L_ADDR_MASK = {{(C_PORT_AWIDTH-2){1'b1}}, 2'b00};

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [7:0]                 r_burst_cnt;
    logic [7:0]                 w_cnt_nxt;
    logic [7:0]                 w_cnt_inc;
    logic                       r_last;
    logic                       w_gnt0;
    logic                       w_gnt1;
    logic                       w_gnt;

    logic                       r_en;
    logic [C_NUM_WE-1:0]        r_wen;
    logic [C_PORT_AWIDTH-1:0]   r_addr;
    logic [C_PORT_DWIDTH-1:0]   r_dout;

    logic [C_NUM_WE-1:0]        w_sel_we;
    logic [C_PORT_AWIDTH-1:0]   w_sel_addr;
    logic [C_PORT_DWIDTH-1:0]   w_sel_wdata;

    logic                       r_tag1_rd;
    logic                       r_tag1_own;
    logic                       r_tag2_rd;
    logic                       r_tag2_own;

    // Grant decision: tie from idle goes to the requester that did not win last; an owner keeps the port until it drops Req or exhausts its burst while the other waits.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            S_OWN0: begin
                if (Req_0 && (!Req_1 || (r_burst_cnt < L_MAX))) begin
                    w_gnt0 = 1'b1;
                end else if (Req_1) begin
                    w_gnt1 = 1'b1;
                end
            end
            S_OWN1: begin
                if (Req_1 && (!Req_0 || (r_burst_cnt < L_MAX))) begin
                    w_gnt1 = 1'b1;
                end else if (Req_0) begin
                    w_gnt0 = 1'b1;
                end
            end
            default: begin
                if (Req_0 && Req_1) begin
                    w_gnt0 = r_last;
                    w_gnt1 = !r_last;
                end else begin
                    w_gnt0 = Req_0;
                    w_gnt1 = Req_1;
                end
            end
        endcase
    end

    // Next owner and burst count: staying with the same owner counts up (saturating), any switch or fresh grant restarts at 1.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
        w_cnt_inc   = (r_burst_cnt >= L_MAX) ? L_MAX : (r_burst_cnt + 8'd1);
        if (w_gnt0) begin
            w_state_nxt = S_OWN0;
            w_cnt_nxt   = (r_state == S_OWN0) ? w_cnt_inc : 8'd1;
        end else if (w_gnt1) begin
            w_state_nxt = S_OWN1;
            w_cnt_nxt   = (r_state == S_OWN1) ? w_cnt_inc : 8'd1;
        end
    end

    assign w_gnt       = w_gnt0 | w_gnt1;
    assign w_sel_we    = w_gnt1 ? WE_1    : WE_0;
    assign w_sel_addr  = w_gnt1 ? Addr_1  : Addr_0;
    assign w_sel_wdata = w_gnt1 ? WData_1 : WData_0;

    // Owner state, burst counter and last-winner record.
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= 8'd0;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_cnt_nxt;
            if (w_gnt) begin
                r_last <= w_gnt1;
            end
        end
    end

    // Registered BRAM port drive; address and data hold when idle so the port only toggles on real commands.
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            r_en   <= 1'b0;
            r_wen  <= '0;
            r_addr <= '0;
            r_dout <= '0;
        end else if (w_gnt) begin
            r_en   <= 1'b1;
            r_wen  <= w_sel_we;
            r_addr <= w_sel_addr & L_ADDR_MASK;
            r_dout <= w_sel_wdata;
        end else begin
            r_en  <= 1'b0;
            r_wen <= '0;
        end
    end

    // Two-stage {is_read, owner} tag that lines up with the BRAM's one-cycle read latency.
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            r_tag1_rd  <= 1'b0;
            r_tag1_own <= 1'b0;
            r_tag2_rd  <= 1'b0;
            r_tag2_own <= 1'b0;
        end else begin
            r_tag1_rd  <= w_gnt && (w_sel_we == '0);
            r_tag1_own <= w_gnt1;
            r_tag2_rd  <= r_tag1_rd;
            r_tag2_own <= r_tag1_own;
        end
    end

    // Ack is gated by reset so a request held during reset is never accepted and then lost.
    assign Ack_0     = w_gnt0 & BRAM_Rst_N;
    assign Ack_1     = w_gnt1 & BRAM_Rst_N;
    assign RValid_0  = r_tag2_rd & !r_tag2_own;
    assign RValid_1  = r_tag2_rd & r_tag2_own;
    assign RData_0   = BRAM_Din & {C_PORT_DWIDTH{BRAM_Rst_N}};
    assign RData_1   = BRAM_Din & {C_PORT_DWIDTH{BRAM_Rst_N}};
    assign BRAM_EN   = r_en;
    assign BRAM_WEN  = r_wen;
    assign BRAM_Addr = r_addr;
    assign BRAM_Dout = r_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Purpose: directed bench for bram_port_arbiter with a WRITE_FIRST BRAM model and a read-data scoreboard.
// Latency: reads are expected two cycles after their Ack, in issue order.
// Backpressure: requests are driven by hand; Ack patterns are checked cycle by cycle.
module tb_bram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_0, req_1;
    logic [3:0]  we_0, we_1;
    logic [31:0] addr_0, addr_1;
    logic [31:0] wdata_0, wdata_1;
    logic        ack_0, ack_1;
    logic [31:0] rdata_0, rdata_1;
    logic        rvalid_0, rvalid_1;
    logic        bram_en;
    logic [3:0]  bram_wen;
    logic [31:0] bram_addr;
    logic [31:0] bram_dout;
    logic [31:0] bram_din;

    typedef struct packed {
        logic        own;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rv_count = 0;
    logic [31:0] mem [0:255];
    logic [31:0] bram_w;

    localparam logic [31:0] D_104 = 32'hCAFE_0104;
    localparam logic [31:0] D_008 = 32'h1122_CC44;

    bram_port_arbiter #(
        .C_PORT_DWIDTH(32),
        .C_PORT_AWIDTH(32),
        .C_NUM_WE(4),
        .C_MAX_BURST(8)
    ) dut (
        .BRAM_Clk(clk),
        .BRAM_Rst_N(rst_n),
        .Req_0(req_0),
        .WE_0(we_0),
        .Addr_0(addr_0),
        .WData_0(wdata_0),
        .Ack_0(ack_0),
        .RData_0(rdata_0),
        .RValid_0(rvalid_0),
        .Req_1(req_1),
        .WE_1(we_1),
        .Addr_1(addr_1),
        .WData_1(wdata_1),
        .Ack_1(ack_1),
        .RData_1(rdata_1),
        .RValid_1(rvalid_1),
        .BRAM_EN(bram_en),
        .BRAM_WEN(bram_wen),
        .BRAM_Addr(bram_addr),
        .BRAM_Dout(bram_dout),
        .BRAM_Din(bram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WRITE_FIRST BRAM: byte lane j of the word is bits [8j+7:8j].
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[65] = D_104;
        mem[2]  = 32'h1122_3344;
    end

    always @(posedge clk) begin
        if (bram_en) begin
            bram_w = mem[bram_addr[9:2]];
            for (int j = 0; j < 4; j++) begin
                if (bram_wen[j]) bram_w[8*j +: 8] = bram_dout[8*j +: 8];
            end
            mem[bram_addr[9:2]] = bram_w;
            bram_din <= bram_w;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({ack_0, ack_1, rvalid_0, rvalid_1, bram_en, bram_wen}), 64'h0);
        chk({tag, "_addr_dout"}, {bram_addr, bram_dout}, 64'h0);
        chk({tag, "_rdata"}, {rdata_0, rdata_1}, 64'h0);
    endtask

    // Read-data monitor: every strobe must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (rvalid_0 || rvalid_1) begin
            exp_t e;
            rv_count++;
            chk("rvalid_onehot", 64'(rvalid_0 & rvalid_1), 64'h0);
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 64'(rvalid_1), 64'h2);
            end else begin
                e = sb.pop_front();
                chk("rvalid_owner", 64'(rvalid_1), 64'(e.own));
                chk("rdata", 64'(rvalid_1 ? rdata_1 : rdata_0), 64'(e.dat));
            end
        end
    end

    initial begin
        logic [16:0] tie_own;
        logic [4:0]  od_r0, od_r1, od_own;
        int          rv_before;

        rst_n = 1'b0;
        req_0 = 1'b0; req_1 = 1'b0;
        we_0 = 4'h0; we_1 = 4'h0;
        addr_0 = 32'h0; addr_1 = 32'h0;
        wdata_0 = 32'h0; wdata_1 = 32'h0;
        tie_own = 17'b0_1111_1111_0000_0000;
        od_r0   = 5'b00111;
        od_r1   = 5'b11110;
        od_own  = 5'b11000;

        // Reset state, with a request held during reset
        repeat (2) @(posedge clk);
        #1;
        req_0 = 1'b1; addr_0 = 32'h0000_0104;
        @(negedge clk);
        all_zero("reset");
        step();
        rst_n = 1'b1; req_0 = 1'b0;
        step();

        // Single read
        req_0 = 1'b1; addr_0 = 32'h0000_0104; we_0 = 4'h0;
        sb.push_back('{own: 1'b0, dat: D_104});
        @(negedge clk);
        chk("rd_ack0", 64'(ack_0), 64'h1);
        chk("rd_ack1", 64'(ack_1), 64'h0);
        step();
        req_0 = 1'b0;
        @(negedge clk);
        chk("rd_en", 64'(bram_en), 64'h1);
        chk("rd_addr", 64'(bram_addr), 64'h104);
        chk("rd_wen", 64'(bram_wen), 64'h0);
        chk("rd_ack0_drop", 64'(ack_0), 64'h0);
        step();
        step();

        // Unaligned address
        req_0 = 1'b1; addr_0 = 32'h0000_0107;
        sb.push_back('{own: 1'b0, dat: D_104});
        @(negedge clk);
        chk("ua_ack0", 64'(ack_0), 64'h1);
        step();
        req_0 = 1'b0;
        @(negedge clk);
        chk("ua_addr", 64'(bram_addr), 64'h104);
        step();

        // Byte write from requester 1, then back-to-back readback
        req_1 = 1'b1; we_1 = 4'b0010; addr_1 = 32'h0000_0008; wdata_1 = 32'hAABB_CCDD;
        @(negedge clk);
        chk("wr_ack1", 64'(ack_1), 64'h1);
        chk("wr_ack0", 64'(ack_0), 64'h0);
        step();
        we_1 = 4'h0;
        sb.push_back('{own: 1'b1, dat: D_008});
        @(negedge clk);
        chk("wr_en", 64'(bram_en), 64'h1);
        chk("wr_wen", 64'(bram_wen), 64'h2);
        chk("wr_addr", 64'(bram_addr), 64'h8);
        chk("wr_dout", 64'(bram_dout), 64'hAABB_CCDD);
        chk("rb_ack1", 64'(ack_1), 64'h1);
        step();
        req_1 = 1'b0;
        @(negedge clk);
        chk("rb_wen", 64'(bram_wen), 64'h0);
        repeat (4) step();

        // Tie from reset: 8 grants to 0, 8 to 1, then back to 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req_0 = 1'b1; addr_0 = 32'h0000_0104; we_0 = 4'h0;
        req_1 = 1'b1; addr_1 = 32'h0000_0008; we_1 = 4'h0;
        for (int c = 0; c < 17; c++) begin
            if (c > 0) step();
            sb.push_back('{own: tie_own[c], dat: tie_own[c] ? D_008 : D_104});
            @(negedge clk);
            chk($sformatf("tie_ack0_c%0d", c), 64'(ack_0), 64'(!tie_own[c]));
            chk($sformatf("tie_ack1_c%0d", c), 64'(ack_1), 64'(tie_own[c]));
        end
        step();
        req_0 = 1'b0; req_1 = 1'b0;
        repeat (4) step();

        // Owner drop: requester 1 takes over in the cycle requester 0 releases
        addr_0 = 32'h0000_0107; addr_1 = 32'h0000_0008;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) step();
            req_0 = od_r0[c];
            req_1 = od_r1[c];
            sb.push_back('{own: od_own[c], dat: od_own[c] ? D_008 : D_104});
            @(negedge clk);
            chk($sformatf("od_ack0_c%0d", c), 64'(ack_0), 64'(!od_own[c]));
            chk($sformatf("od_ack1_c%0d", c), 64'(ack_1), 64'(od_own[c]));
        end
        step();
        req_0 = 1'b0; req_1 = 1'b0;
        repeat (4) step();

        // Reset in the cycle after a read Ack drops the read
        req_0 = 1'b1; addr_0 = 32'h0000_0104; we_0 = 4'h0;
        @(negedge clk);
        chk("mr_ack0", 64'(ack_0), 64'h1);
        step();
        req_0 = 1'b0;
        rst_n = 1'b0;
        rv_before = rv_count;
        #1;
        all_zero("midreset");
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("mr_no_rvalid", 64'(rv_count - rv_before), 64'h0);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
